// File: rtl/gpu_core_pkg.sv
// Shared types for gpu_core_param: opcode and FSM state enums, instruction field positions.
package gpu_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_DIV   = 4'd4,
    OP_CMPGE = 4'd5,
    OP_SHR   = 4'd6,
    OP_SHL   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_XOR   = 4'd10,
    OP_LD    = 4'd11,
    OP_LDI   = 4'd12,
    OP_ST    = 4'd13,
    OP_BNZ   = 4'd14,
    OP_HALT  = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM      = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_DONE     = 3'd7
  } core_state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int A_MSB   = 11;
  localparam int A_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 4;
  localparam int D_MSB   = 3;
  localparam int D_LSB   = 0;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 4;
  localparam int CID_BIT = 11;

  function automatic logic is_alu_op(opcode_e op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/gpu_alu.sv
// Combinational ALU for the register-register opcodes (add through xor).
module gpu_alu
  import gpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_MUL:   y = a * b;
      // Division by zero saturates to all-ones instead of trapping.
      OP_DIV:   y = (b == '0) ? '1 : a / b;
      OP_CMPGE: y = {{(DATA_W-1){1'b0}}, (a >= b)};
      OP_SHR:   y = a >> b[SH_W-1:0];
      OP_SHL:   y = a << b[SH_W-1:0];
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/gpu_core_param.sv
// SIMT lane core: streams in a program, runs it multicycle, signals completion via ready.
// GPU_CORE_PERF_CNT_EN adds the saturating retired_cnt output.
module gpu_core_param
  import gpu_core_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 12,
  parameter int CORE_ID    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              val_ins,
  input  logic [15:0]       instruction,
  output logic              rtr,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] addr_shared_memory,
  output logic [DATA_W-1:0] mem_dat_st,
  input  logic [DATA_W-1:0] mem_dat,
  input  logic              val_data,
`ifdef GPU_CORE_PERF_CNT_EN
  output logic [31:0]       retired_cnt,
`endif
  output core_state_e       dbg_state
);

  localparam int PW = $clog2(IMEM_DEPTH);

  // Handshakes: an instruction beat transfers on a rising clk edge where val_ins && rtr;
  // a memory access is open from mem_req rising until the edge that samples val_data in MEM_WAIT.

  core_state_e       state;
  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] rf [16];
  logic [PW-1:0]     ld_idx;
  logic [PW-1:0]     pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] op_a, op_b, op_d;
  logic [DATA_W-1:0] result;

  opcode_e           op;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] exec_val;
  logic [ADDR_W-1:0] mem_addr;
  logic [PW-1:0]     br_tgt;
  logic              br_taken;
  logic              wb_wr;
  logic              last_pc;
  logic              first_beat;

  assign dbg_state  = state;
  assign op         = opcode_e'(ir[OP_MSB:OP_LSB]);
  assign mem_addr   = ADDR_W'({op_b, op_a});
  assign br_tgt     = PW'(ir[IMM_MSB:IMM_LSB]);
  assign br_taken   = (op == OP_BNZ) && (op_d != '0);
  assign last_pc    = (pc == PW'(IMEM_DEPTH - 1));
  assign first_beat = (state == S_LOAD) && val_ins && rtr && (ld_idx == '0);
  assign wb_wr      = is_alu_op(op) || (op == OP_LD) || (op == OP_LDI) ||
                      ((op == OP_NOP) && ir[CID_BIT]);

  gpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  always_comb begin
    exec_val = result;
    if (is_alu_op(op))     exec_val = alu_y;
    else if (op == OP_LDI) exec_val = DATA_W'(ir[IMM_MSB:IMM_LSB]);
    else if (op == OP_NOP) exec_val = DATA_W'(CORE_ID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_LOAD;
      rtr                <= 1'b1;
      ready              <= 1'b0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      addr_shared_memory <= '0;
      mem_dat_st         <= '0;
      ld_idx             <= '0;
      pc                 <= '0;
      ir                 <= '0;
      op_a               <= '0;
      op_b               <= '0;
      op_d               <= '0;
      result             <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (val_ins && rtr) begin
            imem[ld_idx] <= instruction;
            if (first_beat) ready <= 1'b0;
            if (ld_idx == PW'(IMEM_DEPTH - 1)) begin
              rtr    <= 1'b0;
              ld_idx <= '0;
              pc     <= '0;
              state  <= S_FETCH;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_DECODE;
        end
        S_DECODE: begin
          op_a  <= rf[ir[A_MSB:A_LSB]];
          op_b  <= rf[ir[B_MSB:B_LSB]];
          op_d  <= rf[ir[D_MSB:D_LSB]];
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= exec_val;
          state  <= S_MEM;
        end
        S_MEM: begin
          if ((op == OP_LD) || (op == OP_ST)) begin
            mem_req            <= 1'b1;
            mem_we             <= (op == OP_ST);
            addr_shared_memory <= mem_addr;
            if (op == OP_ST) mem_dat_st <= op_d;
            state              <= S_MEM_WAIT;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM_WAIT: begin
          if (val_data) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (op == OP_LD) result <= mem_dat;
            state   <= S_WB;
          end
        end
        S_WB: begin
          if (wb_wr) rf[ir[D_MSB:D_LSB]] <= result;
          pc <= br_taken ? br_tgt : pc + 1'b1;
          // A taken branch out of the last slot keeps running.
          if ((op == OP_HALT) || (last_pc && !br_taken)) state <= S_DONE;
          else                                           state <= S_FETCH;
        end
        S_DONE: begin
          ready <= 1'b1;
          rtr   <= 1'b1;
          for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
          state <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef GPU_CORE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  retired_cnt <= '0;
    else if (first_beat)                        retired_cnt <= '0;
    else if (state == S_WB && retired_cnt != '1) retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_gpu_core_param.sv
// Bench for gpu_core_param: instruction-level reference interpreter, shared-memory responder
// with random latency, and a scoreboard of expected memory transactions.
module tb_gpu_core_param;
  import gpu_core_pkg::*;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 12;
  localparam int CID    = 7;
  localparam int SH_MOD = 1 << $clog2(DW);
  localparam int TW     = 1 + AW + DW;

  logic          clk, reset;
  logic          val_ins;
  logic [15:0]   instruction;
  logic          rtr, ready, mem_req, mem_we;
  logic [AW-1:0] addr_shared_memory;
  logic [DW-1:0] mem_dat_st, mem_dat;
  logic          val_data, resp_vd, junk_vd;
  core_state_e   dbg_state;
`ifdef GPU_CORE_PERF_CNT_EN
  logic [31:0]   retired_cnt;
`endif

  assign val_data = resp_vd | junk_vd;

  gpu_core_param #(.DATA_W(DW), .IMEM_DEPTH(DEPTH), .ADDR_W(AW), .CORE_ID(CID)) dut (
    .clk                (clk),
    .reset              (reset),
    .val_ins            (val_ins),
    .instruction        (instruction),
    .rtr                (rtr),
    .ready              (ready),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .addr_shared_memory (addr_shared_memory),
    .mem_dat_st         (mem_dat_st),
    .mem_dat            (mem_dat),
    .val_data           (val_data),
`ifdef GPU_CORE_PERF_CNT_EN
    .retired_cnt        (retired_cnt),
`endif
    .dbg_state          (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference state
  logic [15:0]   prog [DEPTH];
  logic [DW-1:0] mrf [16];
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] dut_mem [1 << AW];
  logic [TW-1:0] exp_q [$];
  int            lat_sum;
  int            fixed_lat;
  bit            resp_en;
  bit            exp_ready;

  // Interprets prog against mrf/ref_mem; returns number of retired instructions.
  task automatic model_run(output int n);
    int pc, nxt, op, ad;
    logic [15:0]   w;
    logic [DW-1:0] a, b, d, r;
    bit wr, done, taken;
    pc = 0; n = 0; done = 0;
    while (!done && n < 256) begin
      w  = prog[pc];
      op = int'(w[15:12]);
      a  = mrf[w[11:8]];
      b  = mrf[w[7:4]];
      d  = mrf[w[3:0]];
      ad = (int'(b) * (1 << DW) + int'(a)) % (1 << AW);
      r = '0; wr = 1; taken = 0;
      n++;
      case (op)
        0:  if (w[11]) r = DW'(CID); else wr = 0;
        1:  r = a + b;
        2:  r = a - b;
        3:  r = a * b;
        4:  r = (b == 0) ? {DW{1'b1}} : a / b;
        5:  r = DW'(a >= b);
        6:  r = a >> (int'(b) % SH_MOD);
        7:  r = a << (int'(b) % SH_MOD);
        8:  r = a & b;
        9:  r = a | b;
        10: r = a ^ b;
        11: begin
          r = ref_mem[ad];
          exp_q.push_back({1'b0, AW'(ad), DW'(0)});
        end
        12: r = DW'(w[11:4]);
        13: begin
          wr = 0;
          ref_mem[ad] = d;
          exp_q.push_back({1'b1, AW'(ad), d});
        end
        14: begin
          wr = 0;
          taken = (d != 0);
        end
        default: begin
          wr = 0;
          done = 1;
        end
      endcase
      if (wr) mrf[w[3:0]] = r;
      if (taken) nxt = int'(w[11:4]) % DEPTH;
      else begin
        nxt = pc + 1;
        if (pc == DEPTH - 1) done = 1;
      end
      pc = nxt;
    end
  endtask

  // Random program; branches only jump forward so every program terminates.
  task automatic gen_random_prog();
    for (int i = 0; i < DEPTH; i++) begin
      int op;
      int t;
      logic [15:0] w;
      op = $urandom_range(0, 15);
      w  = 16'($urandom);
      if (op == 15 && $urandom_range(0, 3) != 0) op = 12;
      if (op == 14) begin
        if (i == DEPTH - 1) op = 12;
        else begin
          t = $urandom_range(i + 1, DEPTH - 1);
          w[11:4] = {4'($urandom_range(0, 15)), 4'(t)};
        end
      end
      w[15:12] = 4'(op);
      prog[i] = w;
    end
  endtask

  // driver: stream prog into the core with random gaps and stray val_data pulses
  task automatic load_program();
    check("ready_before_load", ready, exp_ready);
    for (int i = 0; i < DEPTH; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        val_ins = 1'b0;
        instruction = 16'($urandom);
        junk_vd = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      val_ins = 1'b1;
      instruction = prog[i];
      junk_vd = 1'($urandom_range(0, 1));
      check("rtr_during_load", rtr, 1);
      @(posedge clk);
      #1;
      if (i == 0) begin
        check("ready_clr_first_beat", ready, 0);
`ifdef GPU_CORE_PERF_CNT_EN
        check("retired_clr_first_beat", retired_cnt, 0);
`endif
      end
    end
    val_ins = 1'b0;
    junk_vd = 1'b0;
    check("rtr_fall_after_last", rtr, 0);
    exp_ready = 0;
  endtask

  task automatic run_prog(input string tag);
    int n;
    int cyc;
    exp_q.delete();
    lat_sum = 0;
    model_run(n);
    load_program();
    cyc = 0;
    while (!ready && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_cycles_to_ready"}, cyc, 5 * n + lat_sum + 1);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_rtr"}, rtr, 1);
    check({tag, "_txns_left"}, exp_q.size(), 0);
`ifdef GPU_CORE_PERF_CNT_EN
    check({tag, "_retired"}, retired_cnt, n);
`endif
    exp_ready = 1;
  endtask

  // scoreboard + shared-memory responder
  initial begin
    logic [TW-1:0] got, e;
    int lat;
    resp_vd = 1'b0;
    mem_dat = '0;
    forever begin
      @(negedge clk);
      if (!reset && resp_en && mem_req) begin
        lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
        got = {mem_we, addr_shared_memory, mem_we ? mem_dat_st : DW'(0)};
        if (exp_q.size() == 0) check("mem_txn_unexpected", got, 0);
        else begin
          e = exp_q.pop_front();
          check("mem_txn", got, e);
        end
        if (mem_we) dut_mem[addr_shared_memory] = mem_dat_st;
        for (int k = 1; k < lat; k++) begin
          @(negedge clk);
          check("mem_hold", {mem_req, mem_we, addr_shared_memory, mem_we ? mem_dat_st : DW'(0)},
                {1'b1, got});
        end
        mem_dat = dut_mem[got[DW+AW-1:DW]];
        resp_vd = 1'b1;
        @(negedge clk);
        resp_vd = 1'b0;
        lat_sum += lat;
        check("mem_req_drop", mem_req, 0);
      end
    end
  end

  initial begin
    logic [DW-1:0] v;
    int guard;
    reset = 1'b1; val_ins = 1'b0; instruction = '0; junk_vd = 1'b0;
    resp_en = 1; fixed_lat = 0; exp_ready = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      ref_mem[i] = v;
      dut_mem[i] = v;
    end
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rtr", rtr, 1);
    check("rst_ready", ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_addr", addr_shared_memory, 0);
    check("rst_st_data", mem_dat_st, 0);
    check("rst_state", dbg_state, S_LOAD);
`ifdef GPU_CORE_PERF_CNT_EN
    check("rst_retired", retired_cnt, 0);
`endif
    reset = 1'b0;

    // LDI r1,5; LDI r2,3; add r3=r1+r2; 13 NOPs
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = 16'hC051; prog[1] = 16'hC032; prog[2] = 16'h1123;
    run_prog("basic");

    // LD r4 from 0x305 (latency 3), ST r4, ST r3
    ref_mem[12'h305] = 8'hA5;
    dut_mem[12'h305] = 8'hA5;
    fixed_lat = 3;
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = 16'hB124; prog[1] = 16'hD124; prog[2] = 16'hD123;
    run_prog("ldst");
    fixed_lat = 0;

    // LDI r1,2; BNZ r1 -> 4; LDI r5,1 (skipped); NOP; HALT
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = 16'hC021; prog[1] = 16'hE041; prog[2] = 16'hC015; prog[4] = 16'hF000;
    run_prog("branch");

    // div by zero, CID, then expose r7, r9 and the untouched r5 through stores
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = 16'hC376; prog[1] = 16'hC008; prog[2] = 16'h4687; prog[3] = 16'h0809;
    prog[4] = 16'hD127; prog[5] = 16'hD129; prog[6] = 16'hD125;
    run_prog("div_cid");

    // reset while a load is outstanding
    resp_en = 0;
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = 16'hB124;
    load_program();
    guard = 0;
    while (!mem_req && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rstw_mem_req_up", mem_req, 1);
    check("rstw_mem_we", mem_we, 0);
    repeat (2) @(negedge clk);
    check("rstw_mem_req_held", mem_req, 1);
    reset = 1'b1;
    #1;
    check("rstw_async_mem_req", mem_req, 0);
    @(negedge clk);
    check("rstw_mem_req", mem_req, 0);
    check("rstw_rtr", rtr, 1);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    exp_ready = 0;
    @(negedge clk);
    junk_vd = 1'b1;
    @(negedge clk);
    junk_vd = 1'b0;
    check("rstw_late_vd_mem_req", mem_req, 0);
    check("rstw_late_vd_rtr", rtr, 1);
    check("rstw_late_vd_state", dbg_state, S_LOAD);
    resp_en = 1;
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = 16'hC0A1; prog[1] = 16'hC012; prog[2] = 16'h2123; prog[3] = 16'hD123;
    run_prog("after_reset");

    for (int t = 0; t < 14; t++) begin
      gen_random_prog();
      run_prog($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
